// File: rtl/pattern_seq_detector.sv
// Serial MSB-first pattern detector with a loadable target pattern, selectable
// overlapping/non-overlapping matching, and a saturating match counter.
module pattern_seq_detector #(
   parameter int PAT_W = 4,
   parameter int CNT_W = 8
) (
   input  logic             Clk,
   input  logic             rst,
   input  logic             Sequence,
   input  logic             Valid,
   input  logic [PAT_W-1:0] Pattern,
   input  logic             Load,
   input  logic             Overlap,
   input  logic             Clear_Cnt,
   output logic             Detected,
   output logic [CNT_W-1:0] Match_Count
);

   localparam int                FILL_W  = $clog2(PAT_W + 1);
   localparam logic [FILL_W-1:0] FULL    = FILL_W'(PAT_W);
   localparam logic [CNT_W-1:0]  CNT_MAX = '1;

   logic [PAT_W-1:0]  history, hist_nxt, pat_reg;
   logic [FILL_W-1:0] fill, fill_nxt;
   logic              accept, match;

   // Load takes priority over a coincident sample, which is dropped.
   always_comb begin
      accept   = Valid & ~Load;
      hist_nxt = {history[PAT_W-2:0], Sequence};
      fill_nxt = (fill == FULL) ? FULL : fill + 1'b1;
      match    = accept && (fill_nxt == FULL) && (hist_nxt == pat_reg);
   end

   always_ff @(posedge Clk or posedge rst) begin
      if (rst) begin
         history     <= '0;
         fill        <= '0;
         pat_reg     <= '0;
         Detected    <= 1'b0;
         Match_Count <= '0;
      end else begin
         Detected <= match;
         if (Load) begin
            pat_reg <= Pattern;
            history <= '0;
            fill    <= '0;
         end else if (accept) begin
            history <= hist_nxt;
            // Non-overlapping mode restarts the fill so a fresh full window is needed.
            fill    <= (match && !Overlap) ? '0 : fill_nxt;
         end
         if (Clear_Cnt)
            Match_Count <= '0;
         else if (match && (Match_Count != CNT_MAX))
            Match_Count <= Match_Count + 1'b1;
      end
   end

endmodule

// File: tb/tb_pattern_seq_detector.sv
// Randomized and directed bench for pattern_seq_detector; two instances
// (CNT_W=8 and CNT_W=2) share stimulus and are checked against a queue model.
module tb_pattern_seq_detector;

   logic       Clk = 1'b0;
   logic       rst = 1'b1;
   logic       Sequence = 1'b0, Valid = 1'b0, Load = 1'b0, Overlap = 1'b0, Clear_Cnt = 1'b0;
   logic [3:0] Pattern = '0;
   logic       det8, det2;
   logic [7:0] cnt8;
   logic [1:0] cnt2;

   int checks = 0;
   int errors = 0;

   // reference model state
   bit         hist_q[$];
   logic [3:0] m_pat = '0;
   int         m_cnt = 0;
   bit         m_det = 0;

   always #5 Clk = ~Clk;

   pattern_seq_detector #(.PAT_W(4), .CNT_W(8)) dut8 (
      .Clk(Clk), .rst(rst), .Sequence(Sequence), .Valid(Valid), .Pattern(Pattern),
      .Load(Load), .Overlap(Overlap), .Clear_Cnt(Clear_Cnt),
      .Detected(det8), .Match_Count(cnt8));

   pattern_seq_detector #(.PAT_W(4), .CNT_W(2)) dut2 (
      .Clk(Clk), .rst(rst), .Sequence(Sequence), .Valid(Valid), .Pattern(Pattern),
      .Load(Load), .Overlap(Overlap), .Clear_Cnt(Clear_Cnt),
      .Detected(det2), .Match_Count(cnt2));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, "_det8"}, 32'(det8), 32'(m_det));
      chk({tag, "_det2"}, 32'(det2), 32'(m_det));
      chk({tag, "_cnt8"}, 32'(cnt8), 32'((m_cnt > 255) ? 255 : m_cnt));
      chk({tag, "_cnt2"}, 32'(cnt2), 32'((m_cnt > 3) ? 3 : m_cnt));
   endtask

   task automatic model_reset();
      hist_q.delete();
      m_pat = '0;
      m_cnt = 0;
      m_det = 0;
   endtask

   // One clock: drive, take the edge, advance the model, compare.
   task automatic cyc(input string tag, input bit v, input bit s, input bit ld,
                      input logic [3:0] p, input bit ov, input bit clr);
      logic [3:0] win;
      Valid = v; Sequence = s; Load = ld; Pattern = p; Overlap = ov; Clear_Cnt = clr;
      @(posedge Clk);
      #1;
      m_det = 0;
      if (ld) begin
         m_pat = p;
         hist_q.delete();
      end else if (v) begin
         hist_q.push_back(s);
         if (hist_q.size() > 4) void'(hist_q.pop_front());
         if (hist_q.size() == 4) begin
            win = {hist_q[0], hist_q[1], hist_q[2], hist_q[3]};
            if (win == m_pat) begin
               m_det = 1;
               m_cnt++;
               if (!ov) hist_q.delete();
            end
         end
      end
      if (clr) m_cnt = 0;
      check_all(tag);
   endtask

   task automatic feed(input string tag, input logic [15:0] bits, input int n, input bit ov);
      for (int i = n - 1; i >= 0; i--) cyc(tag, 1, bits[i], 0, 4'h0, ov, 0);
   endtask

   initial begin
      logic [3:0] rp;
      bit         rov;
      #1;
      check_all("reset");
      #11 rst = 1'b0;

      // overlapping: 1,0,1,1,0,1,1 -> pulses on samples 4 and 7
      cyc("ld29", 0, 0, 1, 4'b1011, 1, 1);
      feed("ov1", 16'b1011011, 7, 1);
      chk("ov1_final_cnt", 32'(cnt8), 32'd2);

      // non-overlapping on the same stream -> one pulse
      cyc("ld30", 0, 0, 1, 4'b1011, 0, 1);
      feed("ov0", 16'b1011011, 7, 0);
      chk("ov0_final_cnt", 32'(cnt8), 32'd1);

      // Valid gaps leave history intact
      cyc("ld31", 0, 0, 1, 4'b1011, 1, 1);
      feed("gap_a", 16'b10, 2, 1);
      repeat (3) cyc("gap_idle", 0, 1, 0, 4'h0, 1, 0);
      feed("gap_b", 16'b11, 2, 1);
      chk("gap_final_det", 32'(det8), 32'd1);

      // Load discards the coincident sample and flushes history
      cyc("clr32", 0, 0, 0, 4'h0, 1, 1);
      feed("pre_ld", 16'b101, 3, 1);
      cyc("ld32", 1, 1, 1, 4'b0110, 1, 0);
      feed("post_ld", 16'b0110, 4, 1);
      chk("ld_final_cnt", 32'(cnt8), 32'd1);

      // saturation on the narrow counter, then clear with a coincident match
      cyc("ld33", 0, 0, 1, 4'b1111, 1, 1);
      feed("sat", 16'hFF, 8, 1);
      chk("sat_cnt2", 32'(cnt2), 32'd3);
      chk("sat_cnt8", 32'(cnt8), 32'd5);
      cyc("clr_match", 1, 1, 0, 4'h0, 1, 1);
      chk("clr_match_det", 32'(det8), 32'd1);
      chk("clr_match_cnt", 32'(cnt8), 32'd0);

      // randomized traffic
      rov = 1;
      for (int i = 0; i < 3000; i++) begin
         rp = 4'($urandom);
         if ($urandom_range(0, 49) == 0) rov = ~rov;
         cyc("rand", $urandom_range(0, 3) != 0, 1'($urandom),
             $urandom_range(0, 39) == 0, rp, rov, $urandom_range(0, 199) == 0);
      end

      // async reset mid-sequence
      cyc("ld34", 0, 0, 1, 4'b1011, 1, 0);
      feed("pre_rst", 16'hB, 4, 1);
      feed("pre_rst2", 16'b101, 3, 1);
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_all("async_rst");
      Valid = 1; Sequence = 1; Load = 1; Pattern = 4'b1111; Clear_Cnt = 0;
      @(posedge Clk);
      #1;
      check_all("rst_held");
      #2 rst = 1'b0;
      cyc("ld_after", 0, 0, 1, 4'b1011, 1, 0);
      cyc("one_bit", 1, 1, 0, 4'h0, 1, 0);
      chk("flushed_no_pulse", 32'(det8), 32'd0);
      feed("refill", 16'b011, 3, 1);
      chk("refill_pulse", 32'(det8), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
